// File: rtl/data_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_sequencer
// Brief    : Arbitrates core/interrupt data-space accesses onto the single
//            byte-wide memory-map port, splitting word transfers in two.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_sequencer #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              core_req,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic              core_we,
    input  logic              core_word,
    input  logic              core_io_only,
    input  logic [15:0]       core_wdata,

    input  logic              irq_req,
    input  logic [ADDR_W-1:0] irq_addr,
    input  logic              irq_we,
    input  logic              irq_word,
    input  logic              irq_io_only,
    input  logic [15:0]       irq_wdata,

    output logic              core_ack,
    output logic              irq_ack,
    output logic [15:0]       rdata,
    output logic              busy,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_io_only,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    localparam logic c_OWNER_CORE = 1'b0;
    localparam logic c_OWNER_IRQ  = 1'b1;

    state_t              r_state;
    state_t              w_next_state;

    logic                w_irq_grant;
    logic                w_core_grant;
    logic                w_grant;
    logic                w_mem_we;
    logic                w_mem_io_only;

    logic [ADDR_W-1:0]   w_sel_addr;
    logic                w_sel_we;
    logic                w_sel_word;
    logic                w_sel_io_only;
    logic [15:0]         w_sel_wdata;
    logic [ADDR_W-1:0]   w_addr_inc;

    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic                r_word;
    logic                r_io_only;
    logic [15:0]         r_wdata;
    logic                r_owner;
    logic [7:0]          r_lo_byte;
    logic [15:0]         r_rdata;
    logic                r_core_ack;
    logic                r_irq_ack;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [7:0]          r_mem_wdata;

    // A requester whose ack is still high is dropping its req; skip it this cycle.
    always_comb begin
        w_next_state  = r_state;
        w_irq_grant   = 1'b0;
        w_core_grant  = 1'b0;
        w_mem_we      = 1'b0;
        w_mem_io_only = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (irq_req && !r_irq_ack) begin
                    w_irq_grant  = 1'b1;
                    w_next_state = S_LO;
                end else if (core_req && !r_core_ack) begin
                    w_core_grant = 1'b1;
                    w_next_state = S_LO;
                end
            end
            S_LO: begin
                w_mem_we      = r_we;
                w_mem_io_only = r_io_only;
                w_next_state  = r_word ? S_HI : S_FIN;
            end
            S_HI: begin
                w_mem_we      = r_we;
                w_mem_io_only = r_io_only;
                w_next_state  = S_FIN;
            end
            S_FIN: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    assign w_grant       = w_irq_grant | w_core_grant;
    assign w_sel_addr    = w_irq_grant ? irq_addr    : core_addr;
    assign w_sel_we      = w_irq_grant ? irq_we      : core_we;
    assign w_sel_word    = w_irq_grant ? irq_word    : core_word;
    assign w_sel_io_only = w_irq_grant ? irq_io_only : core_io_only;
    assign w_sel_wdata   = w_irq_grant ? irq_wdata   : core_wdata;
    assign w_addr_inc    = r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};

    // Memory address/data are loaded one edge early so they are stable for
    // the whole LO/HI cycle; the registered read returns in the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_word      <= 1'b0;
            r_io_only   <= 1'b0;
            r_wdata     <= 16'h0000;
            r_owner     <= c_OWNER_CORE;
            r_lo_byte   <= 8'h00;
            r_rdata     <= 16'h0000;
            r_core_ack  <= 1'b0;
            r_irq_ack   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 8'h00;
        end else begin
            r_core_ack <= 1'b0;
            r_irq_ack  <= 1'b0;

            if (w_grant) begin
                r_addr      <= w_sel_addr;
                r_we        <= w_sel_we;
                r_word      <= w_sel_word;
                r_io_only   <= w_sel_io_only;
                r_wdata     <= w_sel_wdata;
                r_owner     <= w_irq_grant ? c_OWNER_IRQ : c_OWNER_CORE;
                r_mem_addr  <= w_sel_addr;
                r_mem_wdata <= w_sel_wdata[7:0];
            end

            case (r_state)
                S_LO: begin
                    if (r_word) begin
                        r_mem_addr  <= w_addr_inc;
                        r_mem_wdata <= r_wdata[15:8];
                    end
                end
                S_HI: begin
                    if (!r_we) begin
                        r_lo_byte <= mem_rdata;
                    end
                end
                S_FIN: begin
                    if (!r_we) begin
                        r_rdata <= r_word ? {mem_rdata, r_lo_byte} : {8'h00, mem_rdata};
                    end
                    r_core_ack <= (r_owner == c_OWNER_CORE);
                    r_irq_ack  <= (r_owner == c_OWNER_IRQ);
                end
                default: begin
                end
            endcase
        end
    end

    assign core_ack    = r_core_ack;
    assign irq_ack     = r_irq_ack;
    assign rdata       = r_rdata;
    assign busy        = (r_state != S_IDLE);
    assign mem_addr    = r_mem_addr;
    assign mem_we      = w_mem_we;
    assign mem_io_only = w_mem_io_only;
    assign mem_wdata   = r_mem_wdata;

endmodule
`default_nettype wire
